cic_comp_fir_deci: RTL and testbench



---
 rtl/cic_comp_pkg.sv | 27 ++
 rtl/cic_comp_fir_deci_comp_mac.sv | 47 ++++
 rtl/cic_comp_fir_deci.sv | 178 +++++++++++++++++
 tb/tb_cic_comp_fir_deci.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_comp_pkg.sv
// Shared types, default coefficients and sizing helper for the CIC compensation FIR.
package cic_comp_pkg;

  localparam int unsigned TAPS_DEFAULT = 16;
  localparam int unsigned CW_DEFAULT   = 12;

  // Symmetric droop-compensation taps, Q1.11, sum 2048 for unity DC gain
  localparam logic [TAPS_DEFAULT-1:0][CW_DEFAULT-1:0] COEF_DEFAULT = {
    12'(-8),   12'(-20),  12'(12),   12'(60),
    12'(-30),  12'(-150), 12'(80),   12'(1080),
    12'(1080), 12'(80),   12'(-150), 12'(-30),
    12'(60),   12'(12),   12'(-20),  12'(-8)
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2
  } state_e;

  function automatic int unsigned acc_width(input int unsigned w,
                                            input int unsigned cw,
                                            input int unsigned taps);
    return w + cw + $clog2(taps);
  endfunction

endpackage

// File: rtl/cic_comp_fir_deci_comp_mac.sv
// Single-multiplier accumulator with round-half-up and saturation back to W bits.
module comp_mac #(
  parameter int unsigned W  = 10,
  parameter int unsigned CW = 12,
  parameter int unsigned AW = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic signed [CW-1:0] coef_i,
  input  logic signed [W-1:0]  samp_i,
  output logic signed [W-1:0]  res_c_o
);

  localparam int unsigned PRW = W + CW;
  localparam logic signed [AW-1:0] HALF = AW'(1) <<< (CW - 2);
  localparam logic signed [AW-1:0] MAXV = (AW'(1) <<< (W - 1)) - AW'(1);
  localparam logic signed [AW-1:0] MINV = -(AW'(1) <<< (W - 1));

  logic signed [PRW-1:0] prod_c;
  logic signed [AW-1:0]  acc_q;
  logic signed [AW-1:0]  shr_c;

  assign prod_c = PRW'(coef_i) * PRW'(samp_i);
  assign shr_c  = (acc_q + HALF) >>> (CW - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + AW'(prod_c);
    end
  end

  always_comb begin
    res_c_o = W'(shr_c);
    if (shr_c > MAXV) begin
      res_c_o = W'(MAXV);
    end else if (shr_c < MINV) begin
      res_c_o = W'(MINV);
    end
  end

endmodule

// File: rtl/cic_comp_fir_deci.sv
// Decimate-by-2 CIC droop-compensation FIR: circular sample buffer, one-deep hold
// register and a TAPS-cycle time-multiplexed MAC sequence per output.
module cic_comp_fir_deci
  import cic_comp_pkg::*;
#(
  parameter int unsigned W    = 10,
  parameter int unsigned TAPS = 16,
  parameter int unsigned CW   = 12,
  parameter logic [TAPS-1:0][CW-1:0] COEF = COEF_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                eni_i,
  input  logic signed [W-1:0] in_i,
  output logic                eno_o,
  output logic signed [W-1:0] out_o,
  output logic                busy_o,
  output logic                ovf_o
);

  localparam int unsigned AW = acc_width(W, CW, TAPS);
  localparam int unsigned PW = $clog2(TAPS);

  state_e              state_q, state_d;
  logic                eni_q;
  logic signed [W-1:0] in_q;
  logic signed [W-1:0] smp_q [TAPS];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       base_q, base_d;
  logic [PW-1:0]       tap_q, tap_d;
  logic [PW-1:0]       rd_idx_c;
  logic                phase_q, phase_d;
  logic                hold_valid_q, hold_valid_d;
  logic signed [W-1:0] hold_q, hold_d;
  logic signed [W-1:0] out_q, out_d;
  logic                eno_q, eno_d;
  logic                busy_q;
  logic                ovf_q, ovf_d;
  logic                wr_en_c;
  logic signed [W-1:0] wr_data_c;
  logic                mac_clr_c, mac_en_c;
  logic signed [W-1:0] mac_res_c;

  assign eno_o  = eno_q;
  assign out_o  = out_q;
  assign busy_o = busy_q;
  assign ovf_o  = ovf_q;

  // Newest sample sits at base; tap i reads i samples back, wrapping mod TAPS
  assign rd_idx_c = (base_q >= tap_q) ? (base_q - tap_q)
                                      : (base_q + PW'(TAPS) - tap_q);

  comp_mac #(
    .W  (W),
    .CW (CW),
    .AW (AW)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (mac_clr_c),
    .en_i    (mac_en_c),
    .coef_i  (COEF[tap_q]),
    .samp_i  (smp_q[rd_idx_c]),
    .res_c_o (mac_res_c)
  );

  always_comb begin
    state_d      = state_q;
    wr_en_c      = 1'b0;
    wr_data_c    = in_q;
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    ovf_d        = ovf_q;
    tap_d        = tap_q;
    base_d       = base_q;
    mac_clr_c    = 1'b0;
    mac_en_c     = 1'b0;
    eno_d        = 1'b0;
    out_d        = out_q;

    case (state_q)
      ST_IDLE: begin
        // Held sample drains first; a simultaneous new sample refills the hold
        if (hold_valid_q) begin
          wr_en_c      = 1'b1;
          wr_data_c    = hold_q;
          hold_valid_d = eni_q;
          hold_d       = eni_q ? in_q : hold_q;
        end else if (eni_q) begin
          wr_en_c = 1'b1;
        end
        if (wr_en_c && phase_q) begin
          state_d   = ST_MAC;
          base_d    = wr_ptr_q;
          tap_d     = '0;
          mac_clr_c = 1'b1;
        end
      end
      ST_MAC: begin
        mac_en_c = 1'b1;
        tap_d    = tap_q + PW'(1);
        if (tap_q == PW'(TAPS - 1)) begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        eno_d   = 1'b1;
        out_d   = mac_res_c;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && eni_q) begin
      if (!hold_valid_q) begin
        hold_valid_d = 1'b1;
        hold_d       = in_q;
      end else begin
        ovf_d = 1'b1;
      end
    end

    phase_d  = wr_en_c ? ~phase_q : phase_q;
    wr_ptr_d = wr_ptr_q;
    if (wr_en_c) begin
      wr_ptr_d = (wr_ptr_q == PW'(TAPS - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eni_q        <= 1'b0;
      in_q         <= '0;
      wr_ptr_q     <= '0;
      base_q       <= '0;
      tap_q        <= '0;
      phase_q      <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      out_q        <= '0;
      eno_q        <= 1'b0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      eni_q        <= eni_i;
      in_q         <= in_i;
      wr_ptr_q     <= wr_ptr_d;
      base_q       <= base_d;
      tap_q        <= tap_d;
      phase_q      <= phase_d;
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      out_q        <= out_d;
      eno_q        <= eno_d;
      busy_q       <= (state_d != ST_IDLE);
      ovf_q        <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        smp_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      smp_q[wr_ptr_q] <= wr_data_c;
    end
  end

endmodule

// File: tb/tb_cic_comp_fir_deci.sv
// Directed bench for cic_comp_fir_deci against a sample-level convolution model.
module tb_cic_comp_fir_deci;

  localparam int W    = 10;
  localparam int TAPS = 16;
  localparam int LAT  = TAPS + 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                eni = 1'b0;
  logic signed [W-1:0] din = '0;
  logic                eno;
  logic signed [W-1:0] dout;
  logic                busy;
  logic                ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ev, ec;

  int coef [TAPS] = '{-8, -20, 12, 60, -30, -150, 80, 1080,
                      1080, 80, -150, -30, 60, 12, -20, -8};
  int xs[$];
  int exp_val[$];
  int exp_cyc[$];
  int got[$];

  cic_comp_fir_deci dut (
    .clk    (clk),
    .rst    (rst),
    .eni_i  (eni),
    .in_i   (din),
    .eno_o  (eno),
    .out_o  (dout),
    .busy_o (busy),
    .ovf_o  (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // y[k] = sum COEF[i]*x[2k+1-i], then floor((acc+1024)/2048) clamped to 10 bits
  function automatic int model_y(input int k);
    longint acc, a, q;
    int n;
    acc = 0;
    for (int i = 0; i < TAPS; i++) begin
      n = 2 * k + 1 - i;
      if (n >= 0 && n < xs.size()) acc += longint'(coef[i]) * longint'(xs[n]);
    end
    a = acc + 1024;
    q = a / 2048;
    if ((a % 2048) != 0 && a < 0) q = q - 1;
    if (q > 511) q = 511;
    if (q < -512) q = -512;
    return int'(q);
  endfunction

  function automatic int got_at(input int i);
    return (i < got.size()) ? got[i] : 9999;
  endfunction

  always begin
    @(posedge clk);
    #1;
    checks++;
    if ($isunknown({eno, dout, busy, ovf})) begin
      failures++;
      $display("FAIL xcheck: got unknown outputs eno=%b busy=%b ovf=%b, expected known", eno, busy, ovf);
    end
    if (eno === 1'b1) begin
      if (exp_val.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_eno: got pulse with out=%0d at cycle %0d, expected none", dout, cyc);
      end else begin
        ev = exp_val.pop_front();
        ec = exp_cyc.pop_front();
        got.push_back(int'(dout));
        chk("eno_value", int'(dout), ev);
        if (ec >= 0) chk("eno_cycle", cyc, ec);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    eni = 1'b0;
    xs.delete();
    exp_val.delete();
    exp_cyc.delete();
    got.delete();
    tick(2);
    rst = 1'b0;
  endtask

  // Called at a falling edge; one-cycle eni pulse then idle for the rest of gap
  task automatic send(input int s, input int gap);
    eni = 1'b1;
    din = W'(s);
    xs.push_back(s);
    if ((xs.size() % 2) == 0) begin
      exp_val.push_back(model_y(xs.size() / 2 - 1));
      exp_cyc.push_back(cyc + LAT + 1);
    end
    tick(1);
    eni = 1'b0;
    if (gap > 1) tick(gap - 1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_val.size() != 0 || busy) && n < budget) begin
      tick(1);
      n++;
    end
    chk("drain_pending", exp_val.size(), 0);
  endtask

  task automatic chk_seq(input string nm, input int e [8]);
    for (int i = 0; i < 8; i++) chk(nm, got_at(i), e[i]);
  endtask

  function automatic int burst_s(input int t);
    return 5 * t - 90;
  endfunction

  initial begin
    int t0, bad;

    // reset state
    tick(2);
    rst = 1'b0;
    chk("rst_out", int'(dout), 0);
    chk("rst_eno", int'(eno), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(ovf), 0);

    // impulse at x[0]
    do_reset();
    send(256, 20);
    for (int i = 0; i < 19; i++) send(0, 20);
    wait_drain(100);
    chk_seq("impulse0", '{-2, 8, -19, 135, 10, -4, 2, -1});
    chk("impulse0_count", got.size(), 10);
    chk("impulse0_tail8", got_at(8), 0);
    chk("impulse0_tail9", got_at(9), 0);

    // impulse at x[1]
    do_reset();
    send(0, 20);
    send(256, 20);
    for (int i = 0; i < 14; i++) send(0, 20);
    wait_drain(100);
    chk_seq("impulse1", '{-1, 2, -4, 10, 135, -19, 8, -2});

    // constant input, one sample every 10 clocks
    do_reset();
    for (int i = 0; i < 100; i++) send(200, 10);
    wait_drain(200);
    chk("const_eno_count", got.size(), 50);
    bad = 0;
    for (int k = 7; k < got.size(); k++) if (got[k] != 200) bad++;
    chk("const_settled_bad", bad, 0);
    chk("const_last", got_at(49), 200);
    chk("const_ovf", int'(ovf), 0);

    // positive saturation: sign pattern aligned to the 8th output's window
    do_reset();
    for (int n = 0; n < 16; n++) send((coef[15 - n] > 0) ? 511 : -511, 20);
    wait_drain(100);
    chk("sat_pos", got_at(7), 511);

    do_reset();
    for (int n = 0; n < 16; n++) send((coef[15 - n] > 0) ? -511 : 511, 20);
    wait_drain(100);
    chk("sat_neg", got_at(7), -512);

    // eni held for 40 clocks: accepted s0,s1,s2,s19,s20,s38,s39, rest dropped
    do_reset();
    t0 = cyc;
    xs = '{burst_s(0), burst_s(1), burst_s(2), burst_s(19), burst_s(20), burst_s(38), burst_s(39)};
    exp_val.push_back(model_y(0));
    exp_cyc.push_back(t0 + 1 + LAT + 1);
    exp_val.push_back(model_y(1));
    exp_cyc.push_back(t0 + 20 + LAT + 1);
    exp_val.push_back(model_y(2));
    exp_cyc.push_back(t0 + 39 + LAT + 1);
    for (int t = 0; t < 40; t++) begin
      eni = 1'b1;
      din = W'(burst_s(t));
      tick(1);
    end
    eni = 1'b0;
    wait_drain(100);
    tick(3);
    chk("burst_count", got.size(), 3);
    chk("burst_ovf", int'(ovf), 1);
    chk("burst_busy", int'(busy), 0);

    // reset 5 clocks into MAC aborts the computation and clears ovf
    do_reset();
    eni = 1'b1;
    din = W'(100);
    tick(1);
    eni = 1'b0;
    tick(19);
    eni = 1'b1;
    din = W'(200);
    tick(1);
    eni = 1'b1;
    din = W'(7);
    tick(1);
    eni = 1'b1;
    din = W'(9);
    tick(1);
    eni = 1'b0;
    tick(3);
    chk("abort_busy_pre", int'(busy), 1);
    chk("abort_ovf_pre", int'(ovf), 1);
    do_reset();
    chk("abort_out", int'(dout), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ovf", int'(ovf), 0);
    chk("abort_eno", int'(eno), 0);
    tick(30);
    send(-300, 20);
    send(400, 20);
    wait_drain(100);
    chk("abort_after_count", got.size(), 1);
    chk("abort_after_value", got_at(0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion by cycle %0d, expected finish", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
